// File: rtl/proc_rr_scheduler_if.sv
// Process-swap handshake between control-unit decode, the scheduler and the PC/shift logic.
// The slave modport is the scheduler side and the master modport is the decode/PC side.
interface proc_rr_scheduler_if #(
  parameter int unsigned NPROC = 4,
  parameter int unsigned IDW   = 2,
  parameter int unsigned PC_W  = 10
);
  logic              sched_en;
  logic              halt_in;
  logic [PC_W-1:0]   cur_pc;
  logic              proc_swap;
  logic              kill;
  logic              set_active;
  logic [IDW-1:0]    set_id;
  logic [PC_W-1:0]   set_pc;
  logic              preempt_req;
  logic              swap_valid;
  logic [PC_W-1:0]   next_pc;
  logic [IDW-1:0]    cur_id;
  logic [NPROC-1:0]  active_mask;
  logic              idle;

  modport master (
    output sched_en, halt_in, cur_pc, proc_swap, kill, set_active, set_id, set_pc,
    input  preempt_req, swap_valid, next_pc, cur_id, active_mask, idle
  );

  modport slave (
    input  sched_en, halt_in, cur_pc, proc_swap, kill, set_active, set_id, set_pc,
    output preempt_req, swap_valid, next_pc, cur_id, active_mask, idle
  );
endinterface

// File: rtl/proc_rr_scheduler.sv
// Round-robin time-slice scheduler: PC table, active mask, quantum counter and
// the IDLE/RUN/SAVE/SELECT/LOAD swap sequence feeding the PC register.
module proc_rr_scheduler #(
  parameter int unsigned NPROC   = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned PC_W    = 10,
  parameter int unsigned QUANTUM = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  proc_rr_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SAVE,
    S_SELECT,
    S_LOAD
  } state_t;

  localparam logic [CNT_W-1:0] QLAST = CNT_W'(QUANTUM - 1);

  state_t           state;
  logic [PC_W-1:0]  pc_table [NPROC];
  logic [IDW-1:0]   scan_start;
  logic [CNT_W-1:0] qcnt;
  logic [IDW-1:0]   sel_id;
  logic [IDW-1:0]   scan_idx;
  logic             sel_found;

  // First active slot at or after scan_start, wrapping; scan_start is cur_id+1
  // on a swap (so cur_id is checked last) and 0 when leaving IDLE.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NPROC; k++) begin
      scan_idx = scan_start + IDW'(k);
      if (!sel_found && bus.active_mask[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      scan_start      <= '0;
      qcnt            <= '0;
      bus.cur_id      <= '0;
      bus.active_mask <= '0;
      bus.preempt_req <= 1'b0;
      bus.swap_valid  <= 1'b0;
      bus.next_pc     <= '0;
      bus.idle        <= 1'b1;
      for (int unsigned i = 0; i < NPROC; i++) begin
        pc_table[i] <= '0;
      end
    end else begin
      bus.swap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sched_en && (|bus.active_mask)) begin
            scan_start <= '0;
            bus.idle   <= 1'b0;
            state      <= S_SELECT;
          end
        end
        S_RUN: begin
          if (bus.sched_en && !bus.halt_in) begin
            if (qcnt == QLAST) begin
              bus.preempt_req <= 1'b1;
            end else begin
              qcnt <= qcnt + CNT_W'(1);
            end
          end
          if (bus.kill) begin
            bus.active_mask[bus.cur_id] <= 1'b0;
            scan_start <= bus.cur_id + IDW'(1);
            state      <= S_SELECT;
          end else if (bus.proc_swap) begin
            scan_start <= bus.cur_id + IDW'(1);
            state      <= S_SAVE;
          end
        end
        S_SAVE: begin
          pc_table[bus.cur_id] <= bus.cur_pc;
          state                <= S_SELECT;
        end
        S_SELECT: begin
          // LOAD outputs are registered on entry so they are visible for
          // exactly the one cycle spent in LOAD.
          if (sel_found) begin
            bus.cur_id      <= sel_id;
            bus.next_pc     <= pc_table[sel_id];
            bus.swap_valid  <= 1'b1;
            bus.preempt_req <= 1'b0;
            qcnt            <= '0;
            state           <= S_LOAD;
          end else begin
            bus.idle <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_LOAD: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // An install comes last so it overrides a same-cycle save or kill of that slot.
      if (bus.set_active) begin
        bus.active_mask[bus.set_id] <= 1'b1;
        pc_table[bus.set_id]        <= bus.set_pc;
      end
    end
  end

endmodule

// File: tb/tb_proc_rr_scheduler.sv
// Directed bench for proc_rr_scheduler: a cycle model of the swap protocol is
// compared with the DUT every cycle, and literal expectations pin the model.
module tb_proc_rr_scheduler;

  localparam int NP = 4;
  localparam int QN = 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  proc_rr_scheduler_if #(.NPROC(4), .IDW(2), .PC_W(10)) bus ();

  proc_rr_scheduler #(
    .NPROC(4), .IDW(2), .PC_W(10), .QUANTUM(QN), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must be, tracked as phases of a swap in progress.
  bit       m_idle = 1'b1;
  bit       m_run  = 1'b0;
  bit       m_sv   = 1'b0;
  int       m_busy = 0;     // edges left until the next-process decision (2 = save first)
  int       m_start = 0;
  int       m_q    = 0;     // counted run cycles since the last swap
  int       m_cur  = 0;
  int       m_npc  = 0;
  bit [3:0] m_mask = '0;
  int       m_pc [NP] = '{0, 0, 0, 0};

  function automatic int pick(input int start, input bit [3:0] mask);
    for (int k = 0; k < NP; k++) begin
      int id;
      id = (start + k) % NP;
      if (mask[id]) return id;
    end
    return -1;
  endfunction

  task automatic model_step();
    int s;
    if (reset) begin
      m_idle = 1'b1; m_run = 1'b0; m_sv = 1'b0; m_busy = 0; m_start = 0;
      m_q = 0; m_cur = 0; m_npc = 0; m_mask = '0;
      for (int i = 0; i < NP; i++) m_pc[i] = 0;
      return;
    end
    if (m_sv) begin
      m_sv  = 1'b0;
      m_run = 1'b1;
    end else if (m_busy == 2) begin
      m_pc[m_cur] = int'(bus.cur_pc);
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_busy = 0;
      s = pick(m_start, m_mask);
      if (s < 0) begin
        m_idle = 1'b1;
      end else begin
        m_cur = s; m_npc = m_pc[s]; m_sv = 1'b1; m_q = 0;
      end
    end else if (m_idle) begin
      if (bus.sched_en && m_mask != 0) begin
        m_idle = 1'b0; m_busy = 1; m_start = 0;
      end
    end else if (m_run) begin
      if (bus.sched_en && !bus.halt_in && m_q < QN) m_q++;
      if (bus.kill) begin
        m_mask[m_cur] = 1'b0; m_run = 1'b0; m_busy = 1; m_start = m_cur + 1;
      end else if (bus.proc_swap) begin
        m_run = 1'b0; m_busy = 2; m_start = m_cur + 1;
      end
    end
    if (bus.set_active) begin
      m_mask[bus.set_id] = 1'b1;
      m_pc[bus.set_id]   = int'(bus.set_pc);
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // DUT will sample on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_swap_valid",  {31'b0, bus.swap_valid},  {31'b0, m_sv});
      check("m_idle",        {31'b0, bus.idle},        {31'b0, m_idle});
      check("m_preempt",     {31'b0, bus.preempt_req}, {31'b0, (m_q >= QN)});
      check("m_active_mask", {28'b0, bus.active_mask}, {28'b0, m_mask});
      check("m_cur_id",      {30'b0, bus.cur_id},      m_cur);
      check("m_next_pc",     {22'b0, bus.next_pc},     m_npc);
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) go();
  endtask

  task automatic install(input int id, input int pc);
    bus.set_active = 1'b1;
    bus.set_id     = 2'(id);
    bus.set_pc     = 10'(pc);
    go();
    bus.set_active = 1'b0;
  endtask

  task automatic do_swap(input int pc);
    bus.proc_swap = 1'b1;
    bus.cur_pc    = 10'(pc);
    go();
    bus.proc_swap = 1'b0;
  endtask

  // Counts falling edges until swap_valid is seen; an expired bound is a failure.
  task automatic wait_swap(input int maxc, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.swap_valid) break;
      if (n >= maxc) begin
        checks++;
        failures++;
        $display("FAIL swap_timeout actual=none required=swap_valid within %0d cycles", maxc);
        break;
      end
    end
  endtask

  initial begin
    int n;
    int sv_seen;
    reset = 1'b1;
    bus.sched_en = 1'b1; bus.halt_in = 1'b0; bus.cur_pc = '0;
    bus.proc_swap = 1'b0; bus.kill = 1'b0; bus.set_active = 1'b0;
    bus.set_id = '0; bus.set_pc = '0;
    cyc(2);
    @(negedge clk);
    check("rst_idle",  {31'b0, bus.idle},        32'd1);
    check("rst_mask",  {28'b0, bus.active_mask}, 32'd0);
    check("rst_sv",    {31'b0, bus.swap_valid},  32'd0);
    go();
    reset = 1'b0;

    // Install id0 while idle
    install(0, 'h040);
    wait_swap(8, n);
    check("t1_latency", n, 3);
    check("t1_next_pc", {22'b0, bus.next_pc}, 32'h040);
    check("t1_cur_id",  {30'b0, bus.cur_id},  32'd0);

    // ids 0,1,3 active: round-robin order and saved PCs
    go();
    install(1, 'h100);
    install(3, 'h300);
    do_swap('h050);
    wait_swap(8, n);
    check("t2_cur1",  {30'b0, bus.cur_id},  32'd1);
    check("t2_pc1",   {22'b0, bus.next_pc}, 32'h100);
    go();
    do_swap('h123);
    wait_swap(8, n);
    check("t2_latency", n, 3);
    check("t2_cur3",  {30'b0, bus.cur_id},  32'd3);
    check("t2_pc3",   {22'b0, bus.next_pc}, 32'h300);
    go();
    do_swap('h333);
    wait_swap(8, n);
    check("t2_wrap",    {30'b0, bus.cur_id},  32'd0);
    check("t2_wrap_pc", {22'b0, bus.next_pc}, 32'h050);
    go();
    do_swap('h060);
    wait_swap(8, n);
    check("t2_saved_pc1", {22'b0, bus.next_pc}, 32'h123);

    // Quantum of 8 with a 4-cycle halt in the middle
    go();
    cyc(3);
    bus.halt_in = 1'b1;
    cyc(4);
    bus.halt_in = 1'b0;
    cyc(4);
    @(negedge clk);
    check("t3_pre_after7", {31'b0, bus.preempt_req}, 32'd0);
    go();
    @(negedge clk);
    check("t3_pre_after8", {31'b0, bus.preempt_req}, 32'd1);
    go();
    do_swap('h1AA);
    wait_swap(8, n);
    check("t3_pre_on_load", {31'b0, bus.preempt_req}, 32'd0);
    check("t3_cur3",        {30'b0, bus.cur_id},      32'd3);
    check("t3_pc3",         {22'b0, bus.next_pc},     32'h333);

    // Sole process killed: back to idle without a swap pulse
    go();
    reset = 1'b1;
    go();
    reset = 1'b0;
    install(2, 'h222);
    wait_swap(8, n);
    check("t4_cur2", {30'b0, bus.cur_id},  32'd2);
    check("t4_pc2",  {22'b0, bus.next_pc}, 32'h222);
    go();
    bus.kill = 1'b1;
    go();
    bus.kill = 1'b0;
    @(negedge clk);
    check("t4_mask_cleared", {28'b0, bus.active_mask}, 32'd0);
    sv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.swap_valid) sv_seen++;
    end
    check("t4_no_swap", sv_seen, 0);
    check("t4_idle",    {31'b0, bus.idle}, 32'd1);

    // sched_en low holds IDLE; exit two cycles after enabling
    go();
    bus.sched_en = 1'b0;
    install(2, 'h2B0);
    cyc(3);
    @(negedge clk);
    check("t5_blocked_idle", {31'b0, bus.idle}, 32'd1);
    go();
    bus.sched_en = 1'b1;
    wait_swap(8, n);
    check("t5_idle_exit_latency", n, 3);
    check("t5_pc", {22'b0, bus.next_pc}, 32'h2B0);

    // swap+kill+install of the running slot in one cycle
    go();
    bus.proc_swap = 1'b1; bus.kill = 1'b1; bus.cur_pc = 10'h3FF;
    bus.set_active = 1'b1; bus.set_id = 2'd2; bus.set_pc = 10'h2C0;
    go();
    bus.proc_swap = 1'b0; bus.kill = 1'b0; bus.set_active = 1'b0;
    wait_swap(8, n);
    check("t5_kill_latency", n, 2);
    check("t5_cur2",  {30'b0, bus.cur_id},      32'd2);
    check("t5_newpc", {22'b0, bus.next_pc},     32'h2C0);
    check("t5_mask",  {28'b0, bus.active_mask}, 32'h4);

    // Reset while in SAVE
    go();
    do_swap('h155);
    reset = 1'b1;
    go();
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle",    {31'b0, bus.idle},        32'd1);
    check("t6_mask",    {28'b0, bus.active_mask}, 32'd0);
    check("t6_sv",      {31'b0, bus.swap_valid},  32'd0);
    check("t6_cur_id",  {30'b0, bus.cur_id},      32'd0);
    check("t6_next_pc", {22'b0, bus.next_pc},     32'd0);
    check("t6_preempt", {31'b0, bus.preempt_req}, 32'd0);
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
